// File: rtl/image_stream_reader.sv
// Streams one frame out of the image ROM: sequential reads, 1-cycle ROM latency,
// and a 2-entry buffer that absorbs latency and downstream backpressure.
module image_stream_reader #(
    parameter int unsigned DATA_WIDTH  = 24,
    parameter int unsigned ADDR_WIDTH  = 17,
    parameter int unsigned PIXEL_COUNT = 90000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_read_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  pixel_valid,
    input  logic                  pixel_ready,
    output logic [DATA_WIDTH-1:0] pixel_data,
    output logic                  pixel_last
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXEL_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR  = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] rd_count;
    logic                  inflight;
    logic                  inflight_last;
    logic [1:0]            buf_count;
    entry_t                fifo_q [2];

    logic       pop;
    logic       push;
    logic [2:0] credit;
    logic       issue_last;
    logic [1:0] count_next;
    logic       wr_idx;

    // Credit rule: buffered + in-flight - leaving this cycle must stay below 2.
    assign pop             = pixel_valid & pixel_ready;
    assign push            = inflight;
    assign credit          = 3'(buf_count) + 3'(inflight) - 3'(pop);
    assign mem_read_enable = (state == RUN) && (credit < 3'd2);
    assign issue_last      = mem_read_enable && (rd_count == LAST_ADDR);
    assign count_next      = buf_count + 2'(push) - 2'(pop);
    assign wr_idx          = (buf_count == 2'd2) || ((buf_count == 2'd1) && !pop);

    assign mem_address = rd_count;
    assign pixel_valid = (buf_count != 2'd0);
    assign pixel_data  = fifo_q[0].data;
    assign pixel_last  = fifo_q[0].last;

    // Frame control; DRAIN exits on the edge that empties the buffer so done follows the last transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count_next == 2'd0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Read counter, in-flight tracking and the head-first shift buffer.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_count      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            buf_count     <= 2'd0;
            fifo_q[0]     <= '0;
            fifo_q[1]     <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                rd_count <= '0;
            end else if (mem_read_enable && (rd_count != MAX_ADDR)) begin
                rd_count <= rd_count + ADDR_WIDTH'(1);
            end
            inflight      <= mem_read_enable;
            inflight_last <= issue_last;
            buf_count     <= count_next;
            if (pop) begin
                fifo_q[0] <= fifo_q[1];
            end
            if (push) begin
                fifo_q[wr_idx] <= '{last: inflight_last, data: mem_read_data};
            end
        end
    end

endmodule

// File: tb/tb_image_stream_reader.sv
// Directed bench for image_stream_reader: a 16-pixel instance with a ROM model
// (data = address + 0x100000) and a 1-pixel instance for the single-pixel frame.
module tb_image_stream_reader;

    localparam int unsigned N = 16;

    logic        clock;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        mem_read_enable;
    logic [16:0] mem_address;
    logic [23:0] mem_read_data;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [23:0] pixel_data;
    logic        pixel_last;

    logic        start1;
    logic        busy1;
    logic        done1;
    logic        ren1;
    logic [16:0] addr1;
    logic [23:0] rdata1;
    logic        valid1;
    logic        ready1;
    logic [23:0] data1;
    logic        last1;

    image_stream_reader #(.DATA_WIDTH(24), .ADDR_WIDTH(17), .PIXEL_COUNT(N)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_read_enable(mem_read_enable), .mem_address(mem_address),
        .mem_read_data(mem_read_data), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .pixel_data(pixel_data), .pixel_last(pixel_last)
    );

    image_stream_reader #(.DATA_WIDTH(24), .ADDR_WIDTH(17), .PIXEL_COUNT(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .mem_read_enable(ren1), .mem_address(addr1),
        .mem_read_data(rdata1), .pixel_valid(valid1),
        .pixel_ready(ready1), .pixel_data(data1), .pixel_last(last1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Registered-read ROM models; they drive 0 when not enabled.
    always @(posedge clock) begin
        mem_read_data <= mem_read_enable ? 24'h100000 + 24'(mem_address) : 24'h0;
        rdata1        <= ren1 ? 24'h100000 + 24'(addr1) : 24'h0;
    end

    int vectors     = 0;
    int miscompares = 0;

    int          m_count    = 0;
    logic        m_infl     = 1'b0;
    int          m_addr     = 0;
    int          exp_idx    = 0;
    int          done_count = 0;
    logic        prev_hold  = 1'b0;
    logic [23:0] prev_data  = 24'h0;
    logic        prev_last  = 1'b0;

    typedef struct {
        int          rep;
        logic        s;
        logic        r;
        logic        ren;
        logic [16:0] addr;
        logic        v;
        logic [23:0] d;
        logic        bsy;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_count   = 0;
        m_infl    = 1'b0;
        m_addr    = 0;
        exp_idx   = 0;
        prev_hold = 1'b0;
    endtask

    task automatic begin_frame();
        m_addr     = 0;
        exp_idx    = 0;
        done_count = 0;
    endtask

    // Drive one cycle's inputs, let them settle, then check the stream against the model.
    task automatic settle(input logic s, input logic r);
        logic pop;
        int   occ;
        start       = s;
        pixel_ready = r;
        #1;
        pop = pixel_valid && pixel_ready;
        chk("valid_vs_model", pixel_valid, m_count != 0);
        if (prev_hold && pixel_valid) begin
            chk("hold_data", pixel_data, prev_data);
            chk("hold_last", pixel_last, prev_last);
        end
        if (mem_read_enable) begin
            occ = m_count + int'(m_infl) - int'(pop);
            chk("credit_below_2", occ < 2, 1'b1);
            chk("read_addr", mem_address, m_addr);
        end
        if (pop) begin
            chk("px_data", pixel_data, 24'h100000 + 24'(exp_idx));
            chk("px_last", pixel_last, exp_idx == int'(N) - 1);
            exp_idx++;
        end
        if (done) done_count++;
        m_count   = m_count + int'(m_infl) - int'(pop);
        m_infl    = mem_read_enable;
        if (mem_read_enable) m_addr++;
        prev_hold = pixel_valid && !pixel_ready;
        prev_data = pixel_data;
        prev_last = pixel_last;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_ren"}, mem_read_enable, 1'b0);
        chk({tag, "_addr"}, mem_address, 17'h0);
        chk({tag, "_valid"}, pixel_valid, 1'b0);
        chk({tag, "_data"}, pixel_data, 24'h0);
        chk({tag, "_last"}, pixel_last, 1'b0);
    endtask

    // mode 0: ready high; 1: ready random; 2: ready high with start re-pulsed in RUN and DRAIN.
    task automatic run_frame(input int mode, output int fv, output int dc);
        int   rel;
        logic s;
        logic r;
        begin_frame();
        fv  = -1;
        dc  = -1;
        rel = 0;
        while (dc < 0 && rel < 200) begin
            s = (rel == 0) || (mode == 2 && (rel == 5 || rel == 17 || rel == 18));
            r = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            settle(s, r);
            if (pixel_valid && fv < 0) fv = rel;
            if (done) begin
                dc = rel;
                chk("busy_at_done", busy, 1'b1);
            end
            step();
            rel++;
        end
        settle(1'b0, 1'b1);
        chk("busy_after_done", busy, 1'b0);
        chk("done_one_cycle", done, 1'b0);
        step();
        repeat (3) begin
            settle(1'b0, 1'b1);
            step();
        end
        chk("frame_pixels", exp_idx, N);
        chk("done_pulses", done_count, 1);
    endtask

    initial begin
        int fv;
        int dc;
        int xf;

        tbl[0] = '{rep: 1,  s: 1'b1, r: 1'b0, ren: 1'b0, addr: 17'd0, v: 1'b0, d: 24'h0,      bsy: 1'b0};
        tbl[1] = '{rep: 1,  s: 1'b0, r: 1'b0, ren: 1'b1, addr: 17'd0, v: 1'b0, d: 24'h0,      bsy: 1'b1};
        tbl[2] = '{rep: 1,  s: 1'b0, r: 1'b0, ren: 1'b1, addr: 17'd1, v: 1'b0, d: 24'h0,      bsy: 1'b1};
        tbl[3] = '{rep: 17, s: 1'b0, r: 1'b0, ren: 1'b0, addr: 17'd2, v: 1'b1, d: 24'h100000, bsy: 1'b1};
        tbl[4] = '{rep: 1,  s: 1'b0, r: 1'b1, ren: 1'b1, addr: 17'd2, v: 1'b1, d: 24'h100000, bsy: 1'b1};
        tbl[5] = '{rep: 1,  s: 1'b0, r: 1'b1, ren: 1'b1, addr: 17'd3, v: 1'b1, d: 24'h100001, bsy: 1'b1};
        tbl[6] = '{rep: 1,  s: 1'b0, r: 1'b1, ren: 1'b1, addr: 17'd4, v: 1'b1, d: 24'h100002, bsy: 1'b1};

        reset       = 1'b1;
        start       = 1'b0;
        pixel_ready = 1'b0;
        start1      = 1'b0;
        ready1      = 1'b1;
        step();
        step();
        chk_all_zero("reset");
        reset = 1'b0;

        // Ready held low for 20 cycles from start, then released.
        begin_frame();
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < tbl[i].rep; k++) begin
                settle(tbl[i].s, tbl[i].r);
                chk($sformatf("tbl%0d_ren", i), mem_read_enable, tbl[i].ren);
                chk($sformatf("tbl%0d_addr", i), mem_address, tbl[i].addr);
                chk($sformatf("tbl%0d_valid", i), pixel_valid, tbl[i].v);
                if (tbl[i].v) chk($sformatf("tbl%0d_data", i), pixel_data, tbl[i].d);
                chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
                chk($sformatf("tbl%0d_done", i), done, 1'b0);
                step();
            end
        end
        for (int k = 0; k < 60 && done_count == 0; k++) begin
            settle(1'b0, 1'b1);
            step();
        end
        settle(1'b0, 1'b1);
        chk("stall_frame_pixels", exp_idx, N);
        chk("stall_done_pulses", done_count, 1);
        chk("stall_busy_after", busy, 1'b0);
        step();

        // Full-rate frame: first valid in cycle 3, done in cycle 3+N.
        run_frame(0, fv, dc);
        chk("fullrate_first_valid", fv, 3);
        chk("fullrate_done_cycle", dc, 3 + N);

        run_frame(1, fv, dc);
        chk("random_first_valid", fv, 3);

        run_frame(2, fv, dc);
        chk("restart_done_cycle", dc, 3 + N);

        // Reset during the 8th transfer, then a fresh frame.
        begin_frame();
        settle(1'b1, 1'b1);
        step();
        for (int k = 1; k < 10; k++) begin
            settle(1'b0, 1'b1);
            step();
        end
        chk("pre_reset_idx", exp_idx, 7);
        reset       = 1'b1;
        start       = 1'b0;
        pixel_ready = 1'b1;
        #1;
        chk("pre_reset_valid", pixel_valid, 1'b1);
        chk("pre_reset_data", pixel_data, 24'h100007);
        step();
        reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        reset_model();
        step();
        run_frame(0, fv, dc);
        chk("after_reset_first_valid", fv, 3);
        chk("after_reset_done_cycle", dc, 3 + N);

        // Single-pixel frame.
        xf = 0;
        dc = -1;
        for (int rel = 0; rel < 8; rel++) begin
            start1 = (rel == 0);
            #1;
            if (rel == 1) begin
                chk("pc1_ren_c1", ren1, 1'b1);
                chk("pc1_addr_c1", addr1, 17'd0);
            end
            if (rel == 2) chk("pc1_ren_c2", ren1, 1'b0);
            if (valid1 && ready1) begin
                xf++;
                chk("pc1_data", data1, 24'h100000);
                chk("pc1_last", last1, 1'b1);
                chk("pc1_xfer_cycle", rel, 3);
            end
            if (done1 && dc < 0) dc = rel;
            step();
        end
        chk("pc1_transfers", xf, 1);
        chk("pc1_done_cycle", dc, 4);
        chk("pc1_busy_end", busy1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
